// File: rtl/param_sequencer_fsm.sv
// Parametrised instruction sequencer: fetch/wait/exec FSM with branch, CALL/RET return stack and HALT.
// Optional build macro FLAG_REG_EN: branches test flags registered after each exec_valid instead of live alu_flags.
module param_sequencer_fsm #(
    parameter int ADDR_W      = 8,
    parameter int INSTR_W     = 16,
    parameter int REG_SEL_W   = 2,
    parameter int IMM_W       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [3:0]           alu_flags,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0]   imem_rdata,
    input  logic                 imem_valid,
    output logic                 exec_valid,
    output logic [2:0]           opcode,
    output logic [REG_SEL_W-1:0] rdst,
    output logic [REG_SEL_W-1:0] rsrc1,
    output logic                 src2_sel,
    output logic [IMM_W-1:0]     imm,
    output logic [ADDR_W-1:0]    pc,
    output logic                 halted,
    output logic                 stack_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int MEM_N = 1 << IDX_W;

    localparam logic [2:0] CTRL_OP = 3'b111;
    localparam logic [2:0] C_JMP   = 3'b000;
    localparam logic [2:0] C_BEQ   = 3'b001;
    localparam logic [2:0] C_BNE   = 3'b010;
    localparam logic [2:0] C_BCS   = 3'b011;
    localparam logic [2:0] C_BMI   = 3'b100;
    localparam logic [2:0] C_BVS   = 3'b101;
    localparam logic [2:0] C_CALL  = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                err_q, err_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                push_en;

    logic [ADDR_W-1:0]   stack_mem [MEM_N];
    logic [IDX_W-1:0]    push_idx;
    logic [IDX_W-1:0]    pop_idx;
    logic                stack_full;
    logic                stack_empty;

    logic [2:0]          ir_opcode;
    logic [2:0]          ir_cond;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   pc_inc;
    logic [3:0]          branch_flags;
    logic                branch_taken;

    // Decoded views of the instruction register
    assign ir_opcode = ir_q[INSTR_W-1 -: 3];
    assign ir_cond   = ir_q[INSTR_W-4 -: 3];
    assign target    = ir_q[ADDR_W-1:0];
    assign pc_inc    = pc_q + ADDR_W'(1);

    assign push_idx    = IDX_W'(sp_q);
    assign pop_idx     = IDX_W'(sp_q - SP_W'(1));
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

`ifdef FLAG_REG_EN
    logic [3:0] flags_q;
    logic       exec_seen_q;

    // The ALU result of an issued instruction is settled one cycle after its exec pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q     <= '0;
            exec_seen_q <= 1'b0;
        end else begin
            exec_seen_q <= exec_valid;
            if (exec_seen_q) begin
                flags_q <= alu_flags;
            end
        end
    end

    assign branch_flags = flags_q;
`else
    assign branch_flags = alu_flags;
`endif

    // Flag order is {N,Z,C,V}
    always_comb begin
        branch_taken = 1'b0;
        case (ir_cond)
            C_BEQ:   branch_taken = branch_flags[2];
            C_BNE:   branch_taken = ~branch_flags[2];
            C_BCS:   branch_taken = branch_flags[1];
            C_BMI:   branch_taken = branch_flags[3];
            C_BVS:   branch_taken = branch_flags[0];
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        sp_d       = sp_q;
        err_d      = err_q;
        ir_d       = ir_q;
        push_en    = 1'b0;
        exec_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                state_d = S_FETCH;
                if (ir_opcode != CTRL_OP) begin
                    exec_valid = 1'b1;
                    pc_d       = pc_inc;
                end else begin
                    case (ir_cond)
                        C_JMP: begin
                            pc_d = target;
                        end
                        C_BEQ, C_BNE, C_BCS, C_BMI, C_BVS: begin
                            pc_d = branch_taken ? target : pc_inc;
                        end
                        C_CALL: begin
                            if (stack_full) begin
                                err_d   = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                push_en = 1'b1;
                                sp_d    = sp_q + SP_W'(1);
                                pc_d    = target;
                            end
                        end
                        default: begin
                            // cond 111: imm[0] selects HALT, otherwise RET
                            if (ir_q[0]) begin
                                state_d = S_HALT;
                            end else if (stack_empty) begin
                                err_d   = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                sp_d = sp_q - SP_W'(1);
                                pc_d = stack_mem[pop_idx];
                            end
                        end
                    endcase
                end
            end

            S_HALT: begin
                if (!run) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            ir_q    <= ir_d;
        end
    end

    // Return addresses are pushed already incremented, so the wrap is inherited from pc_inc
    always_ff @(posedge clk) begin
        if (reset && push_en) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign stack_err = err_q;

    assign opcode   = ir_opcode;
    assign rdst     = ir_q[INSTR_W-4 -: REG_SEL_W];
    assign rsrc1    = ir_q[INSTR_W-4-REG_SEL_W -: REG_SEL_W];
    assign src2_sel = ir_q[INSTR_W-4-2*REG_SEL_W];
    assign imm      = ir_q[IMM_W-1:0];

endmodule

// File: tb/tb_param_sequencer_fsm.sv
// Bench for param_sequencer_fsm: directed scenarios followed by random programs checked
// against an instruction-level reference model (PC, return stack, halt and error state).
module tb_param_sequencer_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [3:0]  alu_flags;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        exec_valid;
    logic [2:0]  opcode;
    logic [1:0]  rdst;
    logic [1:0]  rsrc1;
    logic        src2_sel;
    logic [7:0]  imm;
    logic [7:0]  pc;
    logic        halted;
    logic        stack_err;

    always #5 clk = ~clk;

    param_sequencer_fsm #(
        .ADDR_W(8), .INSTR_W(16), .REG_SEL_W(2), .IMM_W(8), .STACK_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .alu_flags(alu_flags),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .exec_valid(exec_valid), .opcode(opcode),
        .rdst(rdst), .rsrc1(rsrc1), .src2_sel(src2_sel), .imm(imm), .pc(pc),
        .halted(halted), .stack_err(stack_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Instruction-level reference model
    int         m_pc;
    int         m_stack[$];
    bit         m_err;
    bit         m_halt;
    logic [3:0] m_freg;
    bit         m_prev_dp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_err = 0;
        m_halt = 0;
        m_freg = 4'h0;
        m_prev_dp = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run = 1'b0;
        imem_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic wait_req(output bit ok);
        int k;
        k = 0;
        while (imem_req !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        ok = (imem_req === 1'b1);
        if (!ok) check("req_timeout", 32'(imem_req), 32'd1);
    endtask

    // Runs one instruction end to end; flags < 0 picks random ALU flags
    task automatic exec_one(input logic [15:0] instr, input int lat, input int flags);
        bit         ok;
        logic [3:0] f;
        logic [3:0] fl;
        int         op, cond, tgt, nxt;
        bit         dp;

        wait_req(ok);
        if (!ok) return;
        check("fetch_addr", 32'(imem_addr), 32'(m_pc));
        f = (flags < 0) ? 4'($urandom) : 4'(flags);
        alu_flags = f;
        if (m_prev_dp) m_freg = f;

        @(negedge clk);
        check("wait_req_low", 32'(imem_req), 32'd0);
        for (int i = 0; i < lat; i++) begin
            check("wait_quiet", 32'({imem_req, exec_valid}), 32'd0);
            @(negedge clk);
        end
        imem_valid = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);

        op   = int'(instr[15:13]);
        cond = int'(instr[12:10]);
        tgt  = int'(instr[7:0]);
        nxt  = (m_pc + 1) % 256;
`ifdef FLAG_REG_EN
        fl = m_freg;
`else
        fl = f;
`endif
        dp = (op != 7);
        check("exec_valid", 32'(exec_valid), 32'(dp));
        if (dp) begin
            check("opcode", 32'(opcode), 32'(op));
            check("rdst", 32'(rdst), 32'(instr[12:11]));
            check("rsrc1", 32'(rsrc1), 32'(instr[10:9]));
            check("src2_sel", 32'(src2_sel), 32'(instr[8]));
            check("imm", 32'(imm), 32'(tgt));
            m_pc = nxt;
        end else begin
            case (cond)
                0: m_pc = tgt;
                1: m_pc = fl[2] ? tgt : nxt;
                2: m_pc = !fl[2] ? tgt : nxt;
                3: m_pc = fl[1] ? tgt : nxt;
                4: m_pc = fl[3] ? tgt : nxt;
                5: m_pc = fl[0] ? tgt : nxt;
                6: begin
                    if (m_stack.size() == 4) begin
                        m_err = 1;
                        m_halt = 1;
                    end else begin
                        m_stack.push_back(nxt);
                        m_pc = tgt;
                    end
                end
                default: begin
                    if (instr[0]) m_halt = 1;
                    else if (m_stack.size() == 0) begin
                        m_err = 1;
                        m_halt = 1;
                    end else m_pc = m_stack.pop_back();
                end
            endcase
        end
        m_prev_dp = dp;

        @(negedge clk);
        check("halted", 32'(halted), 32'(m_halt));
        check("stack_err", 32'(stack_err), 32'(m_err));
        check("pc", 32'(pc), 32'(m_pc));
        check("single_exec", 32'(exec_valid), 32'd0);
        if (!m_halt) check("next_req", 32'(imem_req), 32'd1);
    endtask

    task automatic recover();
        run = 1'b0;
        @(negedge clk);
        check("idle_halted", 32'(halted), 32'd0);
        check("idle_pc", 32'(pc), 32'(m_pc));
        check("idle_err", 32'(stack_err), 32'(m_err));
        m_halt = 0;
        run = 1'b1;
    endtask

    function automatic logic [15:0] rand_instr();
        int r;
        logic [15:0] w;
        r = $urandom_range(0, 99);
        w = 16'($urandom);
        if (r < 55) begin
            if (w[15:13] == 3'b111) w[15:13] = 3'($urandom_range(0, 6));
        end else begin
            w[15:13] = 3'b111;
            if (r < 75)      w[12:10] = 3'($urandom_range(1, 5));
            else if (r < 80) w[12:10] = 3'b000;
            else if (r < 88) w[12:10] = 3'b110;
            else begin
                w[12:10] = 3'b111;
                w[0] = (r >= 96);
            end
        end
        return w;
    endfunction

    initial begin
        bit ok;
        reset = 1'b0;
        run = 1'b0;
        alu_flags = 4'h0;
        imem_rdata = 16'h0;
        imem_valid = 1'b0;

        do_reset();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(stack_err), 32'd0);
        check("rst_exec", 32'(exec_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_imm", 32'(imm), 32'd0);

        // Basic fetch/exec, then a long memory wait
        run = 1'b1;
        exec_one(16'h2A55, 0, -1);
        exec_one(16'h4123, 5, -1);

        // BEQ taken and not taken
        exec_one(16'hE440, 0, 4'b0100);
        exec_one(16'h0000, 1, -1);
        exec_one(16'hE440, 0, 4'b0000);
        exec_one(16'h1BCD, 0, -1);

        // CALL/RET, then stack overflow on the fifth nested CALL
        do_reset();
        run = 1'b1;
        exec_one(16'hE005, 0, -1);
        exec_one(16'hF810, 0, -1);
        exec_one(16'hFC00, 2, -1);
        exec_one(16'h3000, 0, -1);
        for (int i = 0; i < 5; i++) exec_one(16'hF820, 0, -1);
        check("nest_err", 32'(stack_err), 32'd1);
        check("nest_halt", 32'(halted), 32'd1);
        recover();
        exec_one(16'h5111, 0, -1);

        // PC wrap from 0xFF
        do_reset();
        run = 1'b1;
        exec_one(16'hE0FF, 0, -1);
        exec_one(16'h6222, 0, -1);
        exec_one(16'h0001, 0, -1);

        // HALT and resume at the HALT address
        do_reset();
        run = 1'b1;
        exec_one(16'h2A55, 0, -1);
        exec_one(16'h2A55, 0, -1);
        exec_one(16'hFC01, 0, -1);
        recover();
        exec_one(16'h2A55, 0, -1);

        // Reset during WAIT: the late response must be ignored
        wait_req(ok);
        @(negedge clk);
        reset = 1'b0;
        run = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 16'h2A55;
        @(negedge clk);
        imem_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check("late_exec", 32'(exec_valid), 32'd0);
            check("late_pc", 32'(pc), 32'd0);
            check("late_opcode", 32'(opcode), 32'd0);
            check("late_req", 32'(imem_req), 32'd0);
            @(negedge clk);
        end

        // Random programs
        do_reset();
        run = 1'b1;
        for (int n = 0; n < 250; n++) begin
            exec_one(rand_instr(), $urandom_range(0, 3), -1);
            if (m_halt) recover();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
